mmio_uart_tx: RTL
=================

Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the CPU data-memory bus. It is the responder to the CPU's load/store initiator.
- CPU stores bytes to a DATA register. The block buffers them in a small FIFO and serialises them 8N1 on `tx`, LSB first.
- Status and baud divisor are CPU-readable. Register reads are combinational so a single-cycle load sees them in the same cycle.

Parameters:
- `CLK_FREQ`, 1000000: core clock frequency in Hz.
- `BAUD`, 115200: reset baud rate. The reset divisor is `CLK_FREQ/BAUD`, rounded down, minimum 1.
- `FIFO_DEPTH`, 8: TX FIFO entries. Must be a power of two, 2..64.

Ports:
- `clock` in 1: the single clock, rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `sel` in 1: bus select; address decoded to this block.
- `we` in 1: store strobe, valid with `sel`.
- `addr` in 4: byte offset. `0x0` DATA, `0x4` STATUS, `0x8` DIVISOR. `addr[1:0]` ignored.
- `wdata` in 32: store data.
- `rdata` out 32: load data, combinational from `addr`. Zero when `sel`=0 or offset unmapped.
- `tx` out 1: serial line, registered, idle high.
- `irq` out 1: registered; high while FIFO is empty and the shifter is idle.

Behaviour:
- Reset (`resetn`=0 at an edge): FIFO empty, state IDLE, `tx`=1, overflow=0, divisor=reset value, `irq`=1, bit/baud counters 0. Reset mid-frame aborts the frame; `tx` returns to 1 on that edge.
- Write DATA (`sel`&`we`, offset `0x0`): `wdata[7:0]` is pushed at the edge.
  - Push is accepted if count<`FIFO_DEPTH`, or if a pop occurs on the same edge.
  - Otherwise the byte is dropped and sticky overflow is set.
- Read DATA: returns 0.
- STATUS read:
  - bit0 busy (state≠IDLE); bit1 full; bit2 empty; bit3 overflow.
  - bits[15:8] FIFO count; other bits 0.
- STATUS write: `wdata[3]`=1 clears overflow. If a drop occurs on the same edge, set wins.
- DIVISOR (16 bits, `rdata[15:0]`):
  - Written value 0 is stored as 1.
  - A new divisor takes effect at the next bit boundary; the current bit completes with the old count.
- FSM states: IDLE, START, DATA, STOP. The baud counter counts 0..divisor-1; a bit boundary is count=divisor-1.
  - IDLE: if FIFO non-empty at edge E, pop into the shift register, go to START, and drive `tx`=0 from edge E. Latency: a DATA write at edge N into an empty FIFO with state IDLE gives the pop at edge N+1 and `tx`=0 after N+1.
  - START: after divisor clocks, go to DATA, bit index 0, `tx`=`shift[0]`.
  - DATA: each bit lasts divisor clocks, shifting right. After bit 7, go to STOP with `tx`=1.
  - STOP: after divisor clocks, go to IDLE. If the FIFO is non-empty at that boundary, pop immediately and go straight to START (back-to-back frames, no idle gap).
  - Frame length: exactly 10×divisor clocks.
- FIFO: circular buffer with read/write pointers of `log2(FIFO_DEPTH)` bits that wrap modulo depth, plus a separate count (0..`FIFO_DEPTH`).
- `irq`: updated each edge to (empty && state==IDLE) after that edge's updates.

Decomposition:
- Package `mmio_uart_pkg`:
  - register offsets (`UART_DATA`, `UART_STATUS`, `UART_DIV`);
  - STATUS bit positions;
  - FSM state enum (2 bits);
  - divisor width constant (16).
- Sub-module `sync_fifo`:
  - parameters WIDTH, DEPTH;
  - ports `clock`, `resetn`, push, pop, din, dout, count, full, empty;
  - first-word-fall-through output;
  - same push-on-full-with-pop rule.

Test Plan:
- Reset, then read STATUS and DIVISOR (`CLK_FREQ`=1000000, `BAUD`=115200) -> STATUS=`0x00000004`, DIVISOR=8, `tx`=1, `irq`=1.
- Write DIVISOR=4, then DATA=`0x55` -> `tx` samples every 4 clocks are 0,1,0,1,0,1,0,1,0,1. Frame is 40 clocks; busy for exactly 40 clocks; then `irq`=1.
- DIVISOR=1; write `0xA5`, `0x3C` back-to-back -> 20 contiguous bit times (0,10100101 LSB-first,1,0,00111100 LSB-first,1) with no idle gap.
- While busy, write 9 bytes with DIVISOR=16, `FIFO_DEPTH`=8 -> count reaches 8, ninth dropped, STATUS bit3=1. Write STATUS `0x8` -> bit3=0. Exactly 8 further frames transmit.
- Write DIVISOR=0 -> reads back 1. Write DIVISOR=8 mid-bit with old divisor 4 -> current bit lasts 4 clocks, following bits last 8.
- Assert `resetn`=0 for one edge during DATA bit 3 -> `tx`=1 after that edge, FIFO empty, state IDLE, no further transitions on `tx`.

Source files
------------

// File: rtl/mmio_uart_pkg.sv
// mmio_uart_pkg: register map, status bit positions and FSM encoding shared by the MMIO UART
package mmio_uart_pkg;
    localparam logic [3:0] UART_DATA = 4'h0;
    localparam logic [3:0] UART_STATUS = 4'h4;
    localparam logic [3:0] UART_DIV = 4'h8;
    localparam int ST_BUSY = 0;
    localparam int ST_FULL = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF = 3;
    localparam int DIV_W = 16;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through circular FIFO; a push while full is taken if a pop shares the edge
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign empty = count == '0;
    assign full = count == (AW+1)'(DEPTH);
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout = mem[rd_ptr];
    always_ff @(posedge clock)
        if (do_push) mem[wr_ptr] <= din;
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a TX FIFO and programmable baud divisor
module mmio_uart_tx import mmio_uart_pkg::*; #(
    parameter int CLK_FREQ = 1000000,
    parameter int BAUD = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        sel,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        irq
);
    localparam int CW = $clog2(FIFO_DEPTH);
    localparam int RAW_DIV = CLK_FREQ / BAUD;
    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(RAW_DIV < 1 ? 1 : RAW_DIV);
    uart_state_t state;
    logic [DIV_W-1:0] div_reg, div_act, baud_cnt;
    logic [2:0] bit_idx;
    logic [7:0] shift, fifo_dout;
    logic [CW:0] count;
    logic [31:0] status;
    logic full, empty, ovf, bnd, pop, push_ok, idle_next;
    logic wr_data, wr_status, wr_div, unused_ok;
    assign wr_data = sel && we && addr[3:2] == UART_DATA[3:2];
    assign wr_status = sel && we && addr[3:2] == UART_STATUS[3:2];
    assign wr_div = sel && we && addr[3:2] == UART_DIV[3:2];
    assign unused_ok = ^{addr[1:0], wdata[31:16]};
    // div_act holds the divisor for the bit in flight, so divisor writes land on the next bit
    assign bnd = baud_cnt == div_act - DIV_W'(1);
    assign pop = !empty && (state == IDLE || (state == STOP && bnd));
    assign push_ok = wr_data && (!full || pop);
    assign idle_next = empty && (state == IDLE || (state == STOP && bnd));
    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock(clock),
        .resetn(resetn),
        .push(wr_data),
        .pop(pop),
        .din(wdata[7:0]),
        .dout(fifo_dout),
        .count(count),
        .full(full),
        .empty(empty)
    );
    always_comb begin
        status = '0;
        status[ST_BUSY] = state != IDLE;
        status[ST_FULL] = full;
        status[ST_EMPTY] = empty;
        status[ST_OVF] = ovf;
        status[15:8] = 8'(count);
    end
    assign rdata = !sel ? '0
                 : addr[3:2] == UART_STATUS[3:2] ? status
                 : addr[3:2] == UART_DIV[3:2] ? 32'(div_reg) : '0;
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= IDLE;
            tx <= 1'b1;
            irq <= 1'b1;
            ovf <= 1'b0;
            div_reg <= RST_DIV;
            div_act <= RST_DIV;
            baud_cnt <= '0;
            bit_idx <= '0;
            shift <= '0;
        end else begin
            irq <= idle_next && !push_ok;
            if (wr_data && !push_ok) ovf <= 1'b1;
            else if (wr_status && wdata[ST_OVF]) ovf <= 1'b0;
            if (wr_div) div_reg <= wdata[DIV_W-1:0] == '0 ? DIV_W'(1) : wdata[DIV_W-1:0];
            baud_cnt <= (state == IDLE || bnd) ? '0 : baud_cnt + DIV_W'(1);
            if (state == IDLE || bnd) div_act <= div_reg;
            case (state)
                IDLE: if (pop) begin
                    state <= START;
                    shift <= fifo_dout;
                    tx <= 1'b0;
                end
                START: if (bnd) begin
                    state <= DATA;
                    bit_idx <= '0;
                    tx <= shift[0];
                end
                DATA: if (bnd) begin
                    if (bit_idx == 3'd7) begin
                        state <= STOP;
                        tx <= 1'b1;
                    end else begin
                        bit_idx <= bit_idx + 3'd1;
                        shift <= shift >> 1;
                        tx <= shift[1];
                    end
                end
                STOP: if (bnd) begin
                    state <= pop ? START : IDLE;
                    tx <= !pop;
                    if (pop) shift <= fifo_dout;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
